// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory port between instruction fetch (F, read-only)
// and the data stage (D, read/write); one transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [1:0]        m_size,
    output logic              m_unsigned,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_e              state_q;
    logic [SW-1:0]       streak_q, streak_d;
    logic                owner_q;
    logic                m_req_q, m_we_q, m_unsigned_q;
    logic [1:0]          m_size_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic                f_done_q, d_done_q;
    logic [DATA_W-1:0]   f_rdata_q, d_rdata_q;
    logic                d_wins_d;
    logic                capture_d;

    // Memory handshake: m_req/m_* form a request that is held until the cycle
    // m_gnt is high (accepted); m_rvalid then marks m_rdata valid for one cycle
    // and may coincide with m_gnt. m_rvalid outside ISSUE/WAIT is dropped.
    always_comb begin
        d_wins_d  = d_req && (!f_req || (streak_q < LIMIT));
        streak_d  = '0;
        if (d_wins_d && f_req) begin
            streak_d = (streak_q == LIMIT) ? streak_q : streak_q + SW'(1);
        end
        capture_d = ((state_q == ISSUE) && m_gnt && m_rvalid) ||
                    ((state_q == WAIT) && m_rvalid);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            owner_q      <= 1'b0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_size_q     <= 2'b00;
            m_unsigned_q <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (f_req || d_req) begin
                        owner_q  <= d_wins_d;
                        m_req_q  <= 1'b1;
                        streak_q <= streak_d;
                        state_q  <= ISSUE;
                        if (d_wins_d) begin
                            m_we_q       <= d_we;
                            m_size_q     <= d_size;
                            m_unsigned_q <= d_unsigned;
                            m_addr_q     <= d_addr;
                            m_wdata_q    <= d_wdata;
                        end else begin
                            m_we_q       <= 1'b0;
                            m_size_q     <= 2'b10;
                            m_unsigned_q <= 1'b0;
                            m_addr_q     <= f_addr;
                            m_wdata_q    <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (m_gnt) begin
                        m_req_q <= 1'b0;
                        state_q <= m_rvalid ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    f_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Response capture is shared by the ISSUE (gnt+rvalid) and WAIT paths.
            if (capture_d) begin
                if (owner_q) begin
                    d_done_q <= 1'b1;
                    if (!m_we_q) begin
                        d_rdata_q <= m_rdata;
                    end
                end else begin
                    f_done_q  <= 1'b1;
                    f_rdata_q <= m_rdata;
                end
            end
        end
    end

    assign f_done     = f_done_q;
    assign d_done     = d_done_q;
    assign f_rdata    = f_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign m_req      = m_req_q;
    assign m_we       = m_we_q;
    assign m_size     = m_size_q;
    assign m_unsigned = m_unsigned_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;
    assign dbg_state  = state_q;

endmodule
